alu_sub_seq: RTL
================

Name: alu_sub_seq

Overview:
Multi-cycle two's-complement subtractor, the inverse companion of the team's 16-bit add/flag ALU. It computes z = x - y one SLICE-bit slice per clock, rippling a registered borrow between slices. It produces the same flag set as the adder: sign, zero, parity and overflow, with carry replaced by borrow. It sits beside the adder in the datapath and handles compare and subtract under a start/busy/done handshake.

Parameters:
WIDTH, 16, operand and result width; must be an integer multiple of SLICE
SLICE, 4, bits processed per clock; NSLICE = WIDTH/SLICE

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
x  input  WIDTH  minuend, captured on the accepting edge
y  input  WIDTH  subtrahend, captured on the accepting edge
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse; z and flags are updated in the same cycle
z  output  WIDTH  difference x - y mod 2^WIDTH
sign  output  1  z[WIDTH-1]
zero  output  1  1 when z == 0
borrow  output  1  1 when x < y unsigned
parity  output  1  even parity: ~^z, so 1 when z has an even number of ones
overflow  output  1  signed overflow of x - y

Behaviour:
- Reset (async, rst_n=0): go to IDLE. busy=0, done=0, z=0, sign=0, zero=0, borrow=0, parity=0, overflow=0. All internal operand, partial-result, counter and borrow registers are cleared.
- FSM states: IDLE, RUN.
- IDLE with start=1: on the edge, capture x and y, clear the internal borrow, set slice counter=0, set busy=1, and go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, each edge: compute slice k (bits k*SLICE .. k*SLICE+SLICE-1) as x_k - y_k - b. Store the SLICE-bit result into the internal difference register and register the slice borrow-out as b. Increment k.
- RUN, final slice (k = NSLICE-1) edge:
  - Load z from the completed internal difference.
  - Register the flags from that value: sign = z[MSB]; zero = ~|z; parity = ~^z; borrow = final borrow-out; overflow = (x[MSB] & ~y[MSB] & ~z[MSB]) | (~x[MSB] & y[MSB] & z[MSB]), using the captured x and y.
  - Set done=1 and busy=0, and return to IDLE.
- Latency: with start accepted at edge E, done is high in the cycle after edge E+NSLICE. Default is 4 cycles after acceptance.
- done is high for exactly one cycle.
- z and flags hold their last values until the next completion. They do not change at start or during RUN.
- start while busy=1: ignored, no queuing. Captured operands are unaffected by changes on x and y during RUN.
- start high in the done cycle: accepted, because the FSM is already in IDLE. This allows back-to-back operation with one new result every NSLICE+1 cycles.
- rst_n asserted mid-RUN: the operation is abandoned, no done pulse is produced, and all outputs take their reset values immediately.
- Result z must equal the full-width (x - y) mod 2^WIDTH for all operand pairs, including wrap-around.

Test Plan:
- 0x0005 - 0x0003 -> done 4 cycles after accept; z=0x0002, sign=0, zero=0, borrow=0, parity=0, overflow=0.
- 0x1234 - 0x1234 -> z=0x0000, zero=1, parity=1, borrow=0, sign=0, overflow=0.
- 0x0000 - 0x0001 -> z=0xFFFF, sign=1, borrow=1, parity=1, overflow=0. Then 0x7FFF - 0xFFFF -> z=0x8000, sign=1, borrow=1, overflow=1, parity=0.
- 0x8000 - 0x0001 -> z=0x7FFF, overflow=1, sign=0, borrow=0, parity=0. Driving start=1 with x=0xFFFF during this RUN is ignored, and the result is unchanged.
- Start again in the done cycle with 0x0010 - 0x0001 -> busy=1 the next cycle; previous flags are held; done after 4 cycles with z=0x000F, parity=1.
- Pulse rst_n=0 two cycles into RUN -> busy=0, z=0, all flags 0 immediately, and done never pulses. A start issued after reset completes normally.

Source files
------------

// File: rtl/alu_sub_seq.sv
// Multi-cycle two's-complement subtractor: z = x - y computed SLICE bits per clock
// with a registered borrow, producing sign/zero/borrow/parity/overflow flags.
module alu_sub_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             sign,
  output logic             zero,
  output logic             borrow,
  output logic             parity,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  xa_q, xa_d;
  logic [WIDTH-1:0]  ya_q, ya_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              b_q, b_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  z_q, z_d;
  logic              sign_q, sign_d;
  logic              zero_q, zero_d;
  logic              borrow_q, borrow_d;
  logic              parity_q, parity_d;
  logic              ovf_q, ovf_d;

  logic [SLICE-1:0]  xk, yk;
  logic [SLICE:0]    slice_diff;

  // Signed overflow of a subtraction from the operand and result sign bits.
  function automatic logic sub_ovf(input logic xm, input logic ym, input logic zm);
    return (xm & ~ym & ~zm) | (~xm & ym & zm);
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    xa_d       = xa_q;
    ya_d       = ya_q;
    diff_d     = diff_q;
    b_d        = b_q;
    done_d     = 1'b0;
    z_d        = z_q;
    sign_d     = sign_q;
    zero_d     = zero_q;
    borrow_d   = borrow_q;
    parity_d   = parity_q;
    ovf_d      = ovf_q;
    xk         = xa_q[cnt_q*SLICE +: SLICE];
    yk         = ya_q[cnt_q*SLICE +: SLICE];
    // Extra MSB of the widened subtraction is the slice borrow-out.
    slice_diff = {1'b0, xk} - {1'b0, yk} - {{SLICE{1'b0}}, b_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          xa_d    = x;
          ya_d    = y;
          b_d     = 1'b0;
          cnt_d   = '0;
          diff_d  = '0;
        end
      end
      RUN: begin
        diff_d[cnt_q*SLICE +: SLICE] = slice_diff[SLICE-1:0];
        b_d   = slice_diff[SLICE];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NSLICE - 1)) begin
          state_d  = IDLE;
          cnt_d    = '0;
          done_d   = 1'b1;
          z_d      = diff_d;
          sign_d   = diff_d[WIDTH-1];
          zero_d   = ~|diff_d;
          parity_d = ~^diff_d;
          borrow_d = slice_diff[SLICE];
          ovf_d    = sub_ovf(xa_q[WIDTH-1], ya_q[WIDTH-1], diff_d[WIDTH-1]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      xa_q     <= '0;
      ya_q     <= '0;
      diff_q   <= '0;
      b_q      <= 1'b0;
      done_q   <= 1'b0;
      z_q      <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      borrow_q <= 1'b0;
      parity_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xa_q     <= xa_d;
      ya_q     <= ya_d;
      diff_q   <= diff_d;
      b_q      <= b_d;
      done_q   <= done_d;
      z_q      <= z_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      borrow_q <= borrow_d;
      parity_q <= parity_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign z        = z_q;
  assign sign     = sign_q;
  assign zero     = zero_q;
  assign borrow   = borrow_q;
  assign parity   = parity_q;
  assign overflow = ovf_q;

endmodule
